// File: rtl/sdram_host_emulator.sv
// Stand-in for the SDRAM controller host port: a small on-chip array behind
// the controller's handshake, with matching busy windows, refresh stalls and read latency.
module sdram_host_emulator #(
  parameter int HADDR_WIDTH    = 24,
  parameter int MEM_AW         = 8,
  parameter int WR_CYCLES      = 2,
  parameter int RD_CYCLES      = 4,
  parameter int REFRESH_PERIOD = 1000,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HADDR_WIDTH-1:0] haddr,
  input  logic [15:0]            data_input,
  output logic [15:0]            data_output,
  output logic                   busy,
  input  logic                   rd_enable,
  input  logic                   wr_enable,
  output logic                   rd_ready
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, REFRESH} state_t;

  localparam logic [7:0]  LP_WR_LOAD  = 8'(WR_CYCLES - 1);
  localparam logic [7:0]  LP_RD_LOAD  = 8'(RD_CYCLES - 1);
  localparam logic [7:0]  LP_REF_LOAD = 8'(REFRESH_CYCLES - 1);
  localparam logic [15:0] LP_REF_LAST = 16'(REFRESH_PERIOD - 1);

  state_t            r_state;
  logic [7:0]        r_opCnt;
  logic [15:0]       r_refCnt;
  logic              r_refreshPending;
  logic [MEM_AW-1:0] r_addr;
  logic [15:0]       r_mem [0:(1<<MEM_AW)-1];

  logic w_idle;
  logic w_accept;
  logic w_wrap;
  logic w_unusedHaddr;

  assign w_idle        = (r_state == IDLE) && !r_refreshPending;
  assign w_accept      = w_idle && (rd_enable || wr_enable);
  assign w_wrap        = (r_refCnt == LP_REF_LAST);
  assign busy          = !w_idle;
  // Upper address bits alias onto the array and are deliberately dropped.
  assign w_unusedHaddr = ^haddr[HADDR_WIDTH-1:MEM_AW];

  // The write lands at the acceptance edge, so it is committed before its busy window.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && wr_enable)
      r_mem[haddr[MEM_AW-1:0]] <= data_input;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_opCnt          <= 8'd0;
      r_refCnt         <= 16'd0;
      r_refreshPending <= 1'b0;
      r_addr           <= '0;
      data_output      <= 16'h0000;
      rd_ready         <= 1'b0;
    end else begin
      rd_ready <= 1'b0;
      r_refCnt <= w_wrap ? 16'd0 : r_refCnt + 16'd1;

      case (r_state)
        IDLE: begin
          if (r_refreshPending) begin
            r_state          <= REFRESH;
            r_opCnt          <= LP_REF_LOAD;
            r_refreshPending <= 1'b0;
          end else if (wr_enable) begin
            r_state <= WRITE;
            r_opCnt <= LP_WR_LOAD;
          end else if (rd_enable) begin
            r_state <= READ;
            r_opCnt <= LP_RD_LOAD;
            r_addr  <= haddr[MEM_AW-1:0];
          end
        end
        WRITE, REFRESH: begin
          if (r_opCnt == 8'd0) r_state <= IDLE;
          else                 r_opCnt <= r_opCnt - 8'd1;
        end
        READ: begin
          if (r_opCnt == 8'd0) begin
            r_state     <= IDLE;
            data_output <= r_mem[r_addr];
            rd_ready    <= 1'b1;
          end else begin
            r_opCnt <= r_opCnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A wrap on the same edge that starts a refresh still queues the next one.
      if (w_wrap) r_refreshPending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_host_emulator.sv
// Bench for sdram_host_emulator: directed timing checks plus randomized traffic
// compared every cycle against a cycle-count model of the host port.
module tb_sdram_host_emulator;

  localparam int WRC = 2;
  localparam int RDC = 4;
  localparam int RP  = 1000;
  localparam int RC  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] haddr = '0;
  logic [15:0] dataIn = '0;
  logic [15:0] dataOut;
  logic        busy;
  logic        rdEn = 1'b0;
  logic        wrEn = 1'b0;
  logic        rdReady;

  int nChecks = 0;
  int nFails  = 0;
  bit chkEn   = 1'b0;

  sdram_host_emulator #(
    .HADDR_WIDTH(24), .MEM_AW(8), .WR_CYCLES(WRC), .RD_CYCLES(RDC),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .haddr(haddr), .data_input(dataIn),
    .data_output(dataOut), .busy(busy), .rd_enable(rdEn),
    .wr_enable(wrEn), .rd_ready(rdReady)
  );

  always #5 clk = ~clk;

  // Model: busy means an operation still has cycles left or a refresh is owed.
  int          mOpLeft = 0;
  int          mCyc = 0;
  bit          mPending = 0;
  bit          mReadPend = 0;
  bit          mRdy = 0;
  bit          mWrap = 0;
  logic [15:0] mData = '0;
  logic [7:0]  mRdAddr = '0;
  logic [15:0] mMem [256];

  always @(posedge clk) begin
    if (rst) begin
      mOpLeft = 0; mPending = 0; mReadPend = 0; mRdy = 0; mData = '0; mCyc = 0;
    end else begin
      mWrap = ((mCyc % RP) == RP - 1);
      mRdy  = 0;
      if (mOpLeft > 0) begin
        mOpLeft--;
        if (mOpLeft == 0 && mReadPend) begin
          mData = mMem[mRdAddr]; mRdy = 1; mReadPend = 0;
        end
      end else if (mPending) begin
        mPending = 0; mOpLeft = RC;
      end else if (wrEn) begin
        mMem[haddr[7:0]] = dataIn; mOpLeft = WRC;
      end else if (rdEn) begin
        mRdAddr = haddr[7:0]; mReadPend = 1; mOpLeft = RDC;
      end
      if (mWrap) mPending = 1;
      mCyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset the outputs must match the model.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("modelBusy", 16'(busy), 16'(mOpLeft > 0 || mPending));
      checkOutput("modelRdy", 16'(rdReady), 16'(mRdy));
      checkOutput("modelData", dataOut, mData);
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [23:0] a, input logic [15:0] d);
    rdEn = rd; wrEn = wr; haddr = a; dataIn = d;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 100) begin nextCycle(); n++; end
    if (busy) checkOutput("idleTimeout", 16'(busy), 16'd0);
  endtask

  task automatic doWrite(input logic [23:0] a, input logic [15:0] d);
    waitIdle();
    applyStimulus(0, 1, a, d);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
  endtask

  task automatic readWait(input logic [23:0] a, output logic [15:0] d);
    waitIdle();
    applyStimulus(1, 0, a, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    d = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdReady === 1'b1) begin d = dataOut; break; end
    end
  endtask

  task automatic doReset();
    applyStimulus(0, 0, '0, '0);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
  endtask

  logic [15:0] rdData;
  int          rise;
  int          high;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chkEn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idleBusy", 16'(busy), 16'd0);
      checkOutput("idleRdy", 16'(rdReady), 16'd0);
      checkOutput("idleData", dataOut, 16'h0000);
    end

    // Write A55A to 0x10, then read it back with exact cycle timing.
    applyStimulus(0, 1, 24'h000010, 16'hA55A);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    @(negedge clk); checkOutput("wrBusyT1", 16'(busy), 16'd1); checkOutput("wrRdyT1", 16'(rdReady), 16'd0);
    @(negedge clk); checkOutput("wrBusyT2", 16'(busy), 16'd1); checkOutput("wrRdyT2", 16'(rdReady), 16'd0);
    @(negedge clk); checkOutput("wrBusyT3", 16'(busy), 16'd0); checkOutput("wrRdyT3", 16'(rdReady), 16'd0);

    applyStimulus(1, 0, 24'h000010, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("rdBusyWin", 16'(busy), 16'd1);
      checkOutput("rdRdyWin", 16'(rdReady), 16'd0);
    end
    @(negedge clk);
    checkOutput("rdRdyR5", 16'(rdReady), 16'd1);
    checkOutput("rdDataR5", dataOut, 16'hA55A);
    checkOutput("rdBusyR5", 16'(busy), 16'd0);
    @(negedge clk);
    checkOutput("rdRdyR6", 16'(rdReady), 16'd0);
    checkOutput("rdHoldR6", dataOut, 16'hA55A);

    // Aliasing and simultaneous read+write.
    doWrite(24'h000105, 16'h1234);
    readWait(24'h000005, rdData);
    checkOutput("aliasRead", rdData, 16'h1234);

    waitIdle();
    applyStimulus(1, 1, 24'h000020, 16'hBEEF);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("bothNoRdy", 16'(rdReady), 16'd0);
    end
    readWait(24'h000020, rdData);
    checkOutput("bothWrite", rdData, 16'hBEEF);

    // Reset during the second READ cycle abandons the read.
    waitIdle();
    applyStimulus(1, 0, 24'h000010, '0);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", 16'(busy), 16'd0);
    checkOutput("rstData", dataOut, 16'h0000);
    checkOutput("rstRdy", 16'(rdReady), 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("rstNoRdy", 16'(rdReady), 16'd0);
    end
    readWait(24'h000010, rdData);
    checkOutput("rstKeepsMem", rdData, 16'hA55A);

    // Refresh: first stall at cycle 1000 after reset, 9 cycles long.
    doReset();
    rise = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) begin rise = i; break; end
    end
    checkOutput("refreshRise", 16'(rise), 16'd1000);
    applyStimulus(1, 0, 24'h000005, '0);
    high = 1;
    for (int i = 0; i < 50 && busy; i++) begin
      @(negedge clk);
      if (busy) high++;
    end
    checkOutput("refreshLen", 16'(high), 16'd9);
    nextCycle();
    applyStimulus(0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postRefBusy", 16'(busy), 16'd1);
    end
    @(negedge clk);
    checkOutput("postRefRdy", 16'(rdReady), 16'd1);
    checkOutput("postRefData", dataOut, 16'h1234);

    // Random traffic over a fully written array.
    doReset();
    for (int a = 0; a < 256; a++) doWrite(24'(a), 16'($urandom));
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    24'($urandom), 16'($urandom));
      rst = ($urandom_range(0, 299) == 0);
    end
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, '0, '0);
    repeat (20) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
